// File: rtl/squat_pkg.sv
// rtl/squat_pkg.sv - shared types and defaults for the squat cell scheduler
package squat_pkg;

  localparam int CellBytesDefault = 53;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/squat_cell_sched_rr_pick.sv
// rtl/squat_cell_sched_rr_pick.sv - combinational round-robin first-one finder
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest requester at or after ptr wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/squat_cell_sched.sv
// rtl/squat_cell_sched.sv - round-robin cell bus scheduler with forward/drop statistics
module squat_cell_sched
  import squat_pkg::*;
#(
  parameter  int NumRx     = 4,
  parameter  int NumTx     = 4,
  parameter  int CellBytes = CellBytesDefault,
  parameter  int CntWidth  = 16,
  localparam int RxW       = $clog2(NumRx),
  localparam int BW        = $clog2(CellBytes)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_enable,
  input  logic                        cnt_clr,
  input  logic [NumRx-1:0]            rx_req,
  input  logic [NumRx-1:0][NumTx-1:0] rx_fwd,
  input  logic [NumTx-1:0]            tx_ready,
  output logic [NumRx-1:0]            grant,
  output logic [RxW-1:0]              grant_id,
  output logic [NumTx-1:0]            tx_sel,
  output logic [BW-1:0]               byte_idx,
  output logic                        xfer_last,
  output logic                        cell_done,
  output logic [CntWidth-1:0]         cells_fwd,
  output logic [CntWidth-1:0]         cells_drop
);

  sched_state_t         state_q, state_d;
  logic [NumRx-1:0]     grant_q, grant_d;
  logic [RxW-1:0]       grant_id_q, grant_id_d;
  logic [NumTx-1:0]     tx_sel_q, tx_sel_d;
  logic [BW-1:0]        byte_idx_q, byte_idx_d;
  logic                 xfer_last_q, xfer_last_d;
  logic                 cell_done_q, cell_done_d;
  logic [RxW-1:0]       ptr_q, ptr_d;
  logic [CntWidth-1:0]  cells_fwd_q, cells_fwd_d;
  logic [CntWidth-1:0]  cells_drop_q, cells_drop_d;
  logic [NumRx-1:0]     elig;
  logic                 pick_found;
  logic [RxW-1:0]       pick_idx;
  logic                 last_beat;

  assign last_beat = (byte_idx_q == BW'(CellBytes - 1));

  // A requester is eligible when every Tx port its head cell targets is ready; empty vectors always qualify
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumRx; i++) begin
      elig[i] = rx_req[i] && ((rx_fwd[i] & ~tx_ready) == '0);
    end
  end

  rr_pick #(.N(NumRx)) u_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: arbitrate only in IDLE, always finish a started cell
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_enable && pick_found) state_d = XFER;
      XFER:    if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values: latch grant on pick, step beats, retire cell and bump the matching counter
  always_comb begin
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    tx_sel_d     = tx_sel_q;
    byte_idx_d   = byte_idx_q;
    xfer_last_d  = 1'b0;
    cell_done_d  = 1'b0;
    ptr_d        = ptr_q;
    cells_fwd_d  = cells_fwd_q;
    cells_drop_d = cells_drop_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable && pick_found) begin
          grant_d    = NumRx'(1) << pick_idx;
          grant_id_d = pick_idx;
          tx_sel_d   = rx_fwd[pick_idx];
          byte_idx_d = '0;
          ptr_d      = (pick_idx == RxW'(NumRx - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      XFER: begin
        if (last_beat) begin
          grant_d     = '0;
          grant_id_d  = '0;
          tx_sel_d    = '0;
          byte_idx_d  = '0;
          cell_done_d = 1'b1;
          if (|tx_sel_q) cells_fwd_d  = cells_fwd_q + 1'b1;
          else           cells_drop_d = cells_drop_q + 1'b1;
        end else begin
          byte_idx_d  = byte_idx_q + 1'b1;
          xfer_last_d = ((byte_idx_q + 1'b1) == BW'(CellBytes - 1));
        end
      end
      default: ;
    endcase
    if (cnt_clr) begin
      cells_fwd_d  = '0;
      cells_drop_d = '0;
    end
  end

  // Output and datapath registers; reset drops the grant and discards any partial cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      grant_id_q   <= '0;
      tx_sel_q     <= '0;
      byte_idx_q   <= '0;
      xfer_last_q  <= 1'b0;
      cell_done_q  <= 1'b0;
      ptr_q        <= '0;
      cells_fwd_q  <= '0;
      cells_drop_q <= '0;
    end else begin
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      tx_sel_q     <= tx_sel_d;
      byte_idx_q   <= byte_idx_d;
      xfer_last_q  <= xfer_last_d;
      cell_done_q  <= cell_done_d;
      ptr_q        <= ptr_d;
      cells_fwd_q  <= cells_fwd_d;
      cells_drop_q <= cells_drop_d;
    end
  end

  assign grant      = grant_q;
  assign grant_id   = grant_id_q;
  assign tx_sel     = tx_sel_q;
  assign byte_idx   = byte_idx_q;
  assign xfer_last  = xfer_last_q;
  assign cell_done  = cell_done_q;
  assign cells_fwd  = cells_fwd_q;
  assign cells_drop = cells_drop_q;

endmodule
